// File: rtl/out_port_arbiter.sv
// Output-port arbiter: a round-robin token picks which routing unit may load
// the single slot register; the slot drains into the downstream FIFO/link
// whenever that is not full.

// Per-requester view of the token: full flag and protocol-violation detect.
module out_port_arbiter_lane #(
  parameter int IDX_W = 2,
  parameter int LANE  = 0
) (
  input  logic [IDX_W-1:0] tok,
  input  logic             slot_free,
  input  logic             req,
  output logic             full,
  output logic             viol
);
  // full is built only from tok and slot_free so routing units can derive
  // req from it combinationally without creating a loop.
  assign full = !((tok == IDX_W'(LANE)) && slot_free);
  assign viol = req && full;
endmodule

module out_port_arbiter #(
  parameter int DATA_W  = 64,
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   in_packets,
  output logic [NUM_REQ-1:0]          full_out,
  input  logic                        down_full,
  output logic [DATA_W-1:0]           out_packet,
  output logic                        out_wr_en,
  output logic [IDX_W-1:0]            grant_idx,
  output logic [CNT_W-1:0]            pkt_count,
  output logic                        proto_err
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_st_e;

  slot_st_e              st_q, st_d;
  logic [IDX_W-1:0]      tok;
  logic [DATA_W-1:0]     slot;
  logic [DATA_W-1:0]     pkt_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    viol;
  logic                  slot_valid, slot_free, accept, drain;

  assign slot_valid = (st_q == FULL);
  // A drain frees the slot in the same cycle, so back-to-back accepts are allowed.
  assign slot_free  = !slot_valid || !down_full;
  assign drain      = slot_valid && !down_full;
  assign accept     = req[tok] && slot_free;

  assign out_wr_en  = drain;
  assign out_packet = slot;
  assign grant_idx  = tok;

  genvar i;
  generate
    for (i = 0; i < NUM_REQ; i++) begin : g_lane
      assign pkt_arr[i] = in_packets[i*DATA_W +: DATA_W];
      out_port_arbiter_lane #(.IDX_W(IDX_W), .LANE(i)) u_lane (
        .tok       (tok),
        .slot_free (slot_free),
        .req       (req[i]),
        .full      (full_out[i]),
        .viol      (viol[i])
      );
    end
  endgenerate

  // Slot occupancy next state: fills on accept, empties on a drain with no refill.
  always_comb begin
    st_d = st_q;
    case (st_q)
      EMPTY:   if (accept) st_d = FULL;
      FULL:    if (drain && !accept) st_d = EMPTY;
      default: st_d = EMPTY;
    endcase
  end

  // Slot state register and packet capture; reset drops any buffered packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= EMPTY;
      slot <= '0;
    end else begin
      st_q <= st_d;
      if (accept) slot <= pkt_arr[tok];
    end
  end

  // Token rotates every cycle the slot can take a packet, used or not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tok <= '0;
    end else if (slot_free) begin
      tok <= (tok == IDX_W'(NUM_REQ-1)) ? '0 : tok + IDX_W'(1);
    end
  end

  // Forwarded-packet counter (wraps) and sticky protocol-error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= '0;
      proto_err <= 1'b0;
    end else begin
      if (drain) pkt_count <= pkt_count + CNT_W'(1);
      if (|viol) proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_out_port_arbiter.sv
// Randomized bench for out_port_arbiter with a spec-level reference model and
// a packet scoreboard drained by an independent output monitor.
module tb_out_port_arbiter;
  localparam int DW = 64;
  localparam int NR = 4;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*DW-1:0]  in_packets = '0;
  logic              down_full = 1'b0;
  logic [NR-1:0]     full_out;
  logic [DW-1:0]     out_packet;
  logic              out_wr_en;
  logic [1:0]        grant_idx;
  logic [CW-1:0]     pkt_count;
  logic              proto_err;

  out_port_arbiter #(.DATA_W(DW), .NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .in_packets (in_packets),
    .full_out   (full_out),
    .down_full  (down_full),
    .out_packet (out_packet),
    .out_wr_en  (out_wr_en),
    .grant_idx  (grant_idx),
    .pkt_count  (pkt_count),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who holds the token, whether the slot is occupied,
  // how many packets have left, and whether a violation has been seen.
  int          m_tok = 0;
  bit          m_occ = 0;
  int          m_cnt = 0;
  bit          m_err = 0;
  logic [DW-1:0] sbq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every downstream write must match the oldest accepted packet.
  always @(negedge clk) begin
    if (reset_n && out_wr_en === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got packet %0h expected no write at %0t", out_packet, $time);
      end else begin
        chk("out_packet", out_packet, sbq.pop_front());
      end
    end
  end

  task automatic rand_pkts();
    for (int i = 0; i < NR; i++) in_packets[i*DW +: DW] = {$urandom, $urandom};
  endtask

  // One clock cycle: drive, check combinational/registered outputs against
  // the model mid-cycle, then advance the model at the clock edge.
  task automatic cycle(input logic [NR-1:0] r, input logic df);
    logic [NR-1:0] efull;
    bit free, ewr, acc;
    req = r;
    down_full = df;
    free = !m_occ || !df;
    ewr  = m_occ && !df;
    for (int i = 0; i < NR; i++) efull[i] = !(i == m_tok && free);
    @(negedge clk);
    chk("full_out",  {60'b0, full_out},  {60'b0, efull});
    chk("out_wr_en", {63'b0, out_wr_en}, {63'b0, ewr});
    chk("grant_idx", {62'b0, grant_idx}, 64'(m_tok));
    chk("pkt_count", {60'b0, pkt_count}, 64'(m_cnt));
    chk("proto_err", {63'b0, proto_err}, {63'b0, m_err});
    acc = r[m_tok] && free;
    if ((r & efull) != '0) m_err = 1;
    if (ewr) begin m_cnt = (m_cnt + 1) % (1 << CW); m_occ = 0; end
    if (acc) begin sbq.push_back(in_packets[m_tok*DW +: DW]); m_occ = 1; end
    if (free) m_tok = (m_tok + 1) % NR;
    @(posedge clk);
    #1;
  endtask

  // Hold reset with random inputs and check reset values, then release.
  task automatic apply_reset(input int n);
    reset_n = 1'b0;
    sbq.delete();
    m_tok = 0; m_occ = 0; m_cnt = 0; m_err = 0;
    for (int k = 0; k < n; k++) begin
      req = NR'($urandom);
      down_full = 1'(($urandom));
      rand_pkts();
      @(negedge clk);
      chk("rst_full_out",  {60'b0, full_out},  64'b1110);
      chk("rst_out_wr_en", {63'b0, out_wr_en}, 64'd0);
      chk("rst_pkt_count", {60'b0, pkt_count}, 64'd0);
      chk("rst_grant_idx", {62'b0, grant_idx}, 64'd0);
      chk("rst_proto_err", {63'b0, proto_err}, 64'd0);
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
  endtask

  initial begin
    logic df;
    #1;
    // Reset, then the token walks 0,1,2,3,0 with nobody asking.
    apply_reset(3);
    for (int k = 0; k < 5; k++) begin rand_pkts(); cycle('0, 1'b0); end

    // Single requester 2 with a known packet.
    for (int k = 0; k < NR && m_tok != 2; k++) cycle('0, 1'b0);
    rand_pkts();
    in_packets[2*DW +: DW] = 64'hA5A5_0000_0000_0001;
    cycle(4'b0100, 1'b0);
    cycle('0, 1'b0);
    cycle('0, 1'b0);

    // Everyone busy: one packet per cycle in round-robin order (wraps the counter).
    for (int k = 0; k < 40; k++) begin rand_pkts(); cycle(NR'(1 << m_tok), 1'b0); end

    // Backpressure: fill, stall five cycles, release.
    rand_pkts();
    cycle(NR'(1 << m_tok), 1'b0);
    for (int k = 0; k < 5; k++) cycle('0, 1'b1);
    cycle('0, 1'b0);
    cycle('0, 1'b0);

    // Random legal traffic with random backpressure.
    for (int k = 0; k < 200; k++) begin
      rand_pkts();
      df = ($urandom % 4) == 0;
      if (($urandom % 2) && (!m_occ || !df)) cycle(NR'(1 << m_tok), df);
      else cycle('0, df);
    end

    // Protocol violation by requester 1 while it does not hold the token.
    if (m_tok == 1) cycle('0, 1'b0);
    rand_pkts();
    cycle(4'b0010, 1'b0);
    for (int k = 0; k < 4; k++) cycle('0, 1'b0);

    // Random traffic including illegal requests.
    for (int k = 0; k < 100; k++) begin
      rand_pkts();
      cycle(NR'($urandom), 1'(($urandom % 3) == 0));
    end

    // Mid-operation reset with a stalled packet in the slot.
    for (int k = 0; k < 4; k++) cycle('0, 1'b0);
    rand_pkts();
    cycle(NR'(1 << m_tok), 1'b0);
    cycle('0, 1'b1);
    apply_reset(2);
    for (int k = 0; k < 6; k++) cycle('0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/out_port_arbiter.md
Name: out_port_arbiter

Overview:
- Shares one router output port (E, W, N, S or PE link) among the routing_dir_* units that can target it.
- Rotates a single-slot token across requesters and presents per-requester full flags; only the token holder sees full low.
- Buffers one granted packet in a slot register and writes it to the downstream output FIFO/link when that is not full.
- One instance per output port; sits between the routing units and the output FIFO.

Parameters:
- DATA_W, 64, packet width in bits.
- NUM_REQ, 4, number of requesting routing units (index 0..NUM_REQ-1).
- CNT_W, 16, width of the forwarded-packet counter.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  one-cycle request pulse from each routing unit (its X_req).
- in_packets  input  NUM_REQ*DATA_W  flattened packets; requester i occupies bits [i*DATA_W +: DATA_W].
- full_out  output  NUM_REQ  per-requester full flag, wired to the routing unit's full_X input.
- down_full  input  1  downstream FIFO full (registered at source).
- out_packet  output  DATA_W  packet to downstream.
- out_wr_en  output  1  downstream write strobe.
- grant_idx  output  $clog2(NUM_REQ)  current token holder.
- pkt_count  output  CNT_W  packets forwarded downstream.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (async assert, sync release): tok=0, slot_valid=0, slot=0, pkt_count=0, proto_err=0.
  - Resulting outputs: out_wr_en=0, out_packet=0, full_out={1..1,0}, i.e. only bit 0 low.
- Reset asserted mid-operation discards the slot packet; it is never written downstream.
- Drain:
  - out_wr_en = slot_valid && !down_full (combinational); out_packet = slot.
  - On out_wr_en: pkt_count += 1, wrapping modulo 2^CNT_W.
- Slot availability:
  - slot_free = !slot_valid || !down_full; a drain and an accept in the same cycle are allowed.
  - full_out[i] = !(tok==i && slot_free).
  - full_out depends only on registers and down_full. It must not depend on req, because routing units derive req combinationally from full_out.
- Accept:
  - If req[tok] && !full_out[tok]: slot <= packet tok, and slot_valid <= 1.
  - Accept latency: a packet accepted in cycle t appears on out_packet/out_wr_en in cycle t+1 if down_full=0.
- Slot FSM:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain with no accept.
  - FULL -> FULL on drain plus simultaneous accept, or when stalled by down_full.
- Token FSM (tok, round robin):
  - If slot_free, tok <= (tok+1) mod NUM_REQ every cycle, whether or not the holder used it.
  - If !slot_free (slot occupied and down_full=1), tok holds.
  - Worst-case wait for any requester is NUM_REQ cycles while downstream is not full.
- Protocol check: req[i] high in a cycle where full_out[i]=1 sets proto_err (sticky until reset); that packet is ignored.
- grant_idx = tok.
- Requesters whose direction can never target this port have req tied 0; their tokens pass idle.

Test Plan:
1. Reset: hold reset_n=0 with random inputs, then release -> full_out=4'b1110, out_wr_en=0, pkt_count=0, grant_idx=0; then grant_idx steps 0,1,2,3,0 on successive cycles with no requests.
2. Single requester: requester 2 pulses req with 0xA5A5_0000_0000_0001 in the cycle full_out[2]=0 -> next cycle out_wr_en=1 with that packet, pkt_count=1.
3. All four busy, down_full=0: each requester pulses req when its full_out bit drops -> downstream order 0,1,2,3,0,... at one packet per cycle, no proto_err.
4. Backpressure: fill the slot and hold down_full=1 for 5 cycles -> out_wr_en=0, tok frozen, all full_out=1. Release -> packet written the same cycle and tok resumes.
5. Protocol violation: req[1]=1 while full_out[1]=1 -> proto_err=1 and stays high, slot unchanged, no extra downstream write.
6. Wrap and mid-operation reset: preload pkt_count to 0xFFFF (or use CNT_W=4 with 16 drains) -> next drain gives 0. Assert reset_n with slot_valid=1 -> slot discarded, no out_wr_en after release.
